// File: rtl/sync_ram_pkg.sv
// ---------------------------------------------------------------------------
// sync_ram_pkg
// Shared constants for the sync_ram scratch memory: default word width,
// default address width and the derived depth.
// ---------------------------------------------------------------------------
package sync_ram_pkg;

    localparam int RAM_DATA_WIDTH = 4;
    localparam int RAM_ADDR_WIDTH = 4;
    localparam int RAM_DEPTH      = 2 ** RAM_ADDR_WIDTH;

endpackage : sync_ram_pkg

// File: rtl/sync_ram.sv
// ---------------------------------------------------------------------------
// sync_ram
// Single-port synchronous RAM (default 16 x 4) with separate write and read
// enables and a registered read port (one cycle of latency).
//
// Ports:
//   clk   in   system clock, all state updates on the rising edge
//   rst   in   synchronous active-high reset; clears dout and every word
//   we    in   write enable: mem[addr] <= din
//   re    in   read enable:  dout <= mem[addr]
//   addr  in   [ADDR_WIDTH-1:0] shared read/write word address
//   din   in   [DATA_WIDTH-1:0] write data
//   dout  out  [DATA_WIDTH-1:0] registered read data, holds when re=0
// ---------------------------------------------------------------------------
module sync_ram
    import sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d  [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;

    // Next-state for storage and read register.
    // The read samples mem_q (pre-write contents), which gives
    // read-before-write when we and re hit the same address.
    always_comb begin
        mem_d  = mem_q;
        dout_d = dout_q;
        if (we) begin
            mem_d[addr] = din;
        end else begin
            mem_d = mem_q;
        end
        if (re) begin
            dout_d = mem_q[addr];
        end else begin
            dout_d = dout_q;
        end
    end

    // State registers; reset wins over any write/read on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '{default: {DATA_WIDTH{1'b0}}};
            dout_q <= {DATA_WIDTH{1'b0}};
        end else begin
            mem_q  <= mem_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule : sync_ram

// File: tb/tb_sync_ram.sv
// ---------------------------------------------------------------------------
// tb_sync_ram
// Self-checking bench for sync_ram: directed scenarios plus a randomized
// run compared against an array-based reference model of the memory.
// ---------------------------------------------------------------------------
module tb_sync_ram;
    import sync_ram_pkg::*;

    localparam int DW = RAM_DATA_WIDTH;
    localparam int AW = RAM_ADDR_WIDTH;
    localparam int DEPTH = RAM_DEPTH;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;

    // Reference model: memory contents and expected read register.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_dout;

    int n_checks = 0;
    int n_fail   = 0;

    sync_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .re   (re),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance the model on the edge, and
    // return 1 ns after the edge so dout can be sampled.
    task automatic cyc(input logic r, input logic w, input logic rd,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        rst = r; we = w; re = rd; addr = a; din = d;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
            ref_dout = '0;
        end else begin
            if (rd) ref_dout = ref_mem[a];
            if (w)  ref_mem[a] = d;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 1'b1, 1'b0, AW'($urandom), DW'($urandom));
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        n_checks++;
        if (dout !== '0) begin
            n_fail++;
            $display("FAIL reset_dout: got %h expected 0", dout);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b0, 1'b1, AW'(i), '0);
            n_checks++;
            if (dout !== '0) begin
                n_fail++;
                $display("FAIL reset_clear[%0d]: got %h expected 0", i, dout);
            end
        end
    endtask

    task automatic test_write_read();
        cyc(1'b0, 1'b1, 1'b0, 4'd2, 4'd4);
        cyc(1'b0, 1'b1, 1'b0, 4'd5, 4'd7);
        cyc(1'b0, 1'b0, 1'b1, 4'd2, 4'd0);
        n_checks++;
        if (dout !== 4'd4) begin
            n_fail++;
            $display("FAIL write_read_a2: got %h expected 4", dout);
        end
        cyc(1'b0, 1'b0, 1'b1, 4'd5, 4'd0);
        n_checks++;
        if (dout !== 4'd7) begin
            n_fail++;
            $display("FAIL write_read_a5: got %h expected 7", dout);
        end
    endtask

    task automatic test_hold();
        cyc(1'b0, 1'b1, 1'b0, 4'd5, 4'd9);
        n_checks++;
        if (dout !== 4'd7) begin
            n_fail++;
            $display("FAIL hold_during_write: got %h expected 7", dout);
        end
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        n_checks++;
        if (dout !== 4'd7) begin
            n_fail++;
            $display("FAIL hold_idle: got %h expected 7", dout);
        end
        cyc(1'b0, 1'b0, 1'b1, 4'd5, 4'd0);
        n_checks++;
        if (dout !== 4'd9) begin
            n_fail++;
            $display("FAIL hold_reread: got %h expected 9", dout);
        end
    endtask

    task automatic test_read_before_write();
        cyc(1'b0, 1'b1, 1'b0, 4'd3, 4'hA);
        cyc(1'b0, 1'b1, 1'b1, 4'd3, 4'hC);
        n_checks++;
        if (dout !== 4'hA) begin
            n_fail++;
            $display("FAIL rbw_old: got %h expected a", dout);
        end
        cyc(1'b0, 1'b0, 1'b1, 4'd3, 4'h0);
        n_checks++;
        if (dout !== 4'hC) begin
            n_fail++;
            $display("FAIL rbw_new: got %h expected c", dout);
        end
    endtask

    task automatic test_sweep();
        logic [AW-1:0] a;
        logic [DW-1:0] exp_v;
        for (int i = 0; i < DEPTH; i++) begin
            a = AW'(i);
            cyc(1'b0, 1'b1, 1'b0, a, DW'(~a));
        end
        for (int i = 0; i < DEPTH; i++) begin
            a = AW'(i);
            exp_v = DW'(DEPTH - 1 - i);
            cyc(1'b0, 1'b0, 1'b1, a, '0);
            n_checks++;
            if (dout !== exp_v) begin
                n_fail++;
                $display("FAIL sweep[%0d]: got %h expected %h", i, dout, exp_v);
            end
        end
    endtask

    task automatic test_reset_priority();
        cyc(1'b0, 1'b0, 1'b1, 4'd4, 4'd0);
        cyc(1'b1, 1'b1, 1'b1, 4'd4, 4'd6);
        n_checks++;
        if (dout !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_prio_dout: got %h expected 0", dout);
        end
        cyc(1'b0, 1'b0, 1'b1, 4'd4, 4'd0);
        n_checks++;
        if (dout !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_prio_mem: got %h expected 0", dout);
        end
    endtask

    task automatic test_random();
        logic r, w, rd;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            w  = $urandom_range(0, 1) == 1;
            rd = $urandom_range(0, 1) == 1;
            cyc(r, w, rd, AW'($urandom), DW'($urandom));
            n_checks++;
            if (dout !== ref_dout) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, dout, ref_dout);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 'x;
        ref_dout = 'x;
        cyc(1'b1, 1'b0, 1'b0, '0, '0);
        test_reset();
        test_write_read();
        test_hold();
        test_read_before_write();
        test_sweep();
        test_reset_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_ram
